// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Serial pattern detector with a run-time programmable pattern of 1..MAX_LEN
//   bits. The reset default (pattern 101011, length 6) behaves like the fixed
//   6-bit detector it replaces.
//
//   Optional feature macro: SEQ_DETECTOR_MATCH_COUNT_EN
//     defined   -> saturating match counter drives match_count
//     undefined -> no counter flops; match_count is tied to 0
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   data_in      serial data bit
//   in_valid     data_in is consumed this cycle when high
//   overlap_en   1: overlapping matches allowed, 0: progress cleared after a match
//   pat_load     load pat_in / len_in this cycle (data bit is dropped)
//   pat_in       new pattern; bit [len-1] is received first, bit [0] last
//   len_in       new pattern length (0 clamps to 1, >MAX_LEN clamps to MAX_LEN)
//   data_out     one-cycle registered match pulse
//   state        valid history bits, capped at the current length
//   match_count  saturating count of matches
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PAT = 8'b0010_1011,
    parameter int DEFAULT_LEN = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data_in,
    input  logic               in_valid,
    input  logic               overlap_en,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LEN_W-1:0]   len_in,
    output logic               data_out,
    output logic [LEN_W-1:0]   state,
    output logic [CNT_W-1:0]   match_count
);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] hist_q;

    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   len_clamped;
    logic               accept;
    logic               match;

    // pat_load wins over a data bit presented in the same cycle
    assign accept     = in_valid && !pat_load;
    assign hist_shift = {hist_q[MAX_LEN-2:0], data_in};
    assign fill_inc   = {1'b0, state} + 1'b1;

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    always_comb begin
        fill_next = state;
        if (fill_inc >= {1'b0, len_q}) begin
            fill_next = len_q;
        end else begin
            fill_next = fill_inc[LEN_W-1:0];
        end
    end

    // Only the low len bits take part; state guards against stale history
    assign match = accept && (fill_inc >= {1'b0, len_q}) &&
                   (((hist_shift ^ pat_q) & len_mask) == '0);

    always_comb begin
        len_clamped = len_in;
        if (len_in == '0) begin
            len_clamped = LEN_W'(1);
        end else if (int'(len_in) > MAX_LEN) begin
            len_clamped = LEN_W'(MAX_LEN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q    <= DEFAULT_PAT;
            len_q    <= LEN_W'(DEFAULT_LEN);
            hist_q   <= '0;
            state    <= '0;
            data_out <= 1'b0;
        end else if (pat_load) begin
            pat_q    <= pat_in;
            len_q    <= len_clamped;
            hist_q   <= '0;
            state    <= '0;
            data_out <= 1'b0;
        end else begin
            data_out <= match;
            if (accept) begin
                if (match && !overlap_en) begin
                    // non-overlap: the next match must be built from fresh bits
                    hist_q <= '0;
                    state  <= '0;
                end else begin
                    hist_q <= hist_shift;
                    state  <= fill_next;
                end
            end
        end
    end

`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_count = cnt_q;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset, data_in, in_valid, overlap_en, pat_load;
    logic [7:0] pat_in;
    logic [3:0] len_in;
    logic       data_out, data_out2;
    logic [3:0] state, state2;
    logic [7:0] match_count;
    logic [1:0] match_count2;

    int vecs = 0;
    int errs = 0;
    int exp_n = 0;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
        .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
        .len_in(len_in), .data_out(data_out), .state(state),
        .match_count(match_count)
    );

    seq_detector_param #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
        .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
        .len_in(len_in), .data_out(data_out2), .state(state2),
        .match_count(match_count2)
    );

    // expected counter value given the number of matches since reset
    function automatic logic [7:0] cexp(input int n, input int maxv);
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
        cexp = 8'((n > maxv) ? maxv : n);
`else
        cexp = 8'd0;
`endif
    endfunction

    // apply one cycle of inputs, return #1 after the edge
    task automatic step(input logic d, input logic v);
        data_in  = d;
        in_valid = v;
        @(posedge clk);
        #1;
        pat_load = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0);
        exp_n = 0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic d, input logic v);
        pat_in   = p;
        len_in   = l;
        pat_load = 1'b1;
        step(d, v);
    endtask

    task automatic chk_out(input string nm, input logic exp_d, input logic [3:0] exp_s);
        vecs++;
        if (data_out !== exp_d || state !== exp_s) begin
            errs++;
            $display("FAIL %s: data_out=%b state=%0d, required data_out=%b state=%0d",
                     nm, data_out, state, exp_d, exp_s);
        end
    endtask

    task automatic chk_cnt(input string nm);
        vecs++;
        if (match_count !== cexp(exp_n, 255)) begin
            errs++;
            $display("FAIL %s: match_count=%0d required %0d", nm, match_count, cexp(exp_n, 255));
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk_out("reset_out", 1'b0, 4'd0);
        chk_cnt("reset_cnt");
    endtask

    task automatic test_default();
        logic [5:0] bits = 6'b101011;
        overlap_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(bits[5-i], 1'b1);
            chk_out($sformatf("default_bit%0d", i), (i == 5), 4'(i + 1));
        end
        exp_n++;
        chk_cnt("default_cnt");
        step(1'b0, 1'b0);
        chk_out("default_after", 1'b0, 4'd6);
    endtask

    task automatic test_overlap(input logic ov);
        logic [5:0] bits = 6'b101010;
        logic [5:0] pulse;
        logic [3:0] st;
        overlap_en = ov;
        load(8'b1010, 4'd4, 1'b1, 1'b1);
        chk_out("ovl_load", 1'b0, 4'd0);
        pulse = ov ? 6'b000101 : 6'b000100;
        for (int i = 0; i < 6; i++) begin
            step(bits[5-i], 1'b1);
            if (!ov && i >= 3) st = 4'(i - 3);
            else st = 4'((i + 1 > 4) ? 4 : i + 1);
            chk_out($sformatf("ovl%0d_bit%0d", ov, i), pulse[5-i], st);
            if (pulse[5-i]) exp_n++;
        end
        chk_cnt($sformatf("ovl%0d_cnt", ov));
    endtask

    task automatic test_gaps();
        logic [5:0] bits = 6'b101011;
        overlap_en = 1'b1;
        load(8'b0010_1011, 4'd6, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(bits[5-i], 1'b1);
            chk_out($sformatf("gap_bit%0d", i), (i == 5), 4'(i + 1));
            for (int g = 0; g < 3; g++) begin
                step(g[0], 1'b0);
                chk_out($sformatf("gap_idle%0d_%0d", i, g), 1'b0, 4'(i + 1));
            end
        end
        exp_n++;
        chk_cnt("gap_cnt");
    endtask

    task automatic test_reload();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        load(8'b11, 4'd2, 1'b1, 1'b1);
        chk_out("reload_load", 1'b0, 4'd0);
        step(1'b1, 1'b1);
        chk_out("reload_b1", 1'b0, 4'd1);
        step(1'b1, 1'b1);
        chk_out("reload_b2", 1'b1, 4'd2);
        exp_n++;
        chk_cnt("reload_cnt");
    endtask

    task automatic test_clamp();
        logic [2:0] b3 = 3'b101;
        logic [7:0] b8 = 8'hA5;
        overlap_en = 1'b0;
        load(8'h01, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(b3[2-i], 1'b1);
            chk_out($sformatf("len1_bit%0d", i), b3[2-i], b3[2-i] ? 4'd0 : 4'd1);
            if (b3[2-i]) exp_n++;
        end
        chk_cnt("len1_cnt");
        overlap_en = 1'b1;
        load(8'hA5, 4'd15, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(b8[7-i], 1'b1);
            chk_out($sformatf("len8_bit%0d", i), (i == 7), 4'(i + 1));
        end
        exp_n++;
        chk_cnt("len8_cnt");
    endtask

    task automatic test_sat_reset();
        logic [5:0] bits = 6'b101011;
        do_reset();
        overlap_en = 1'b1;
        for (int m = 0; m < 5; m++)
            for (int i = 0; i < 6; i++) step(bits[5-i], 1'b1);
        exp_n = 5;
        chk_cnt("sat_cnt8");
        vecs++;
        if (match_count2 !== cexp(5, 3)) begin
            errs++;
            $display("FAIL sat_cnt2: match_count=%0d required %0d", match_count2, cexp(5, 3));
        end
        for (int i = 0; i < 5; i++) step(bits[5-i], 1'b1);
        do_reset();
        step(1'b1, 1'b1);
        chk_out("rst_mid", 1'b0, 4'd1);
        chk_cnt("rst_mid_cnt");
        vecs++;
        if (match_count2 !== 2'd0 || state2 !== 4'd1) begin
            errs++;
            $display("FAIL rst_mid_dut2: count=%0d state=%0d required 0 and 1", match_count2, state2);
        end
    endtask

    initial begin
        reset = 1'b1; data_in = 1'b0; in_valid = 1'b0; overlap_en = 1'b1;
        pat_load = 1'b0; pat_in = '0; len_in = '0;
        test_reset();
        test_default();
        test_overlap(1'b1);
        test_overlap(1'b0);
        test_gaps();
        test_reload();
        test_clamp();
        test_sat_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
